// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder for a CPU data port.
// One request in flight at a time. A request is accepted in IDLE, counted
// down in WAIT, and answered with a one-cycle MemReady pulse in RESP.
// Address, data and op are captured at accept, so later input changes
// have no effect on the in-flight access.
//
//   state  | meaning
//   -------+----------------------------------------------
//   IDLE   | ready to accept a request
//   WAIT   | latency countdown, requests ignored
//   RESP   | MemReady=1, store commits at exit
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LAT         = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWriteM,
    input  logic        MemByte,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemErr
);

    localparam int          IW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int          CW    = $clog2(LAT + 1);
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic            w_accept;

    logic            r_we, r_byte, r_err;
    logic [IW-1:0]   r_idx;
    logic [1:0]      r_lane;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_in_err;
    logic            w_ld_err, w_ld_we, w_ld_byte;
    logic [IW-1:0]   w_ld_idx;
    logic [1:0]      w_ld_lane;
    logic [31:0]     w_word;
    logic [7:0]      w_rbyte;

    // Live decode of the request: out-of-range or misaligned word access.
    assign w_in_err = ({1'b0, ALUResult} >= LIMIT) ||
                      (!MemByte && (ALUResult[1:0] != 2'b00));

    // Next-state and countdown logic.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (MemReq) begin
                    w_accept   = 1'b1;
                    w_cnt_next = CW'(LAT - 1);
                    w_next     = (LAT == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) w_next = S_RESP;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State and counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Capture the request at accept.
    always_ff @(posedge clk) begin
        if (reset && w_accept) begin
            r_we    <= MemWriteM;
            r_byte  <= MemByte;
            r_err   <= w_in_err;
            r_idx   <= ALUResult[IW+1:2];
            r_lane  <= ALUResult[1:0];
            r_wdata <= WriteData;
        end
    end

    // When LAT=1 the RESP load happens on the accept edge itself, so the
    // read path takes the live inputs while IDLE and the captured ones after.
    always_comb begin
        w_ld_err  = r_err;
        w_ld_we   = r_we;
        w_ld_byte = r_byte;
        w_ld_idx  = r_idx;
        w_ld_lane = r_lane;
        if (r_state == S_IDLE) begin
            w_ld_err  = w_in_err;
            w_ld_we   = MemWriteM;
            w_ld_byte = MemByte;
            w_ld_idx  = ALUResult[IW+1:2];
            w_ld_lane = ALUResult[1:0];
        end
    end

    assign w_word = r_mem[w_ld_idx];

    // Little-endian byte lane select for byte loads.
    always_comb begin
        w_rbyte = w_word[7:0];
        case (w_ld_lane)
            2'd0:    w_rbyte = w_word[7:0];
            2'd1:    w_rbyte = w_word[15:8];
            2'd2:    w_rbyte = w_word[23:16];
            default: w_rbyte = w_word[31:24];
        endcase
    end

    // Read data register, loaded on the edge entering RESP, held otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rdata <= 32'h0;
        end else if (w_next == S_RESP && r_state != S_RESP) begin
            if (w_ld_err)
                r_rdata <= 32'h0;
            else if (!w_ld_we)
                r_rdata <= w_ld_byte ? {24'h0, w_rbyte} : w_word;
        end
    end

    // Store commit on the RESP->IDLE edge; reset at that edge cancels it.
    always_ff @(posedge clk) begin
        if (reset && r_state == S_RESP && r_we && !r_err) begin
            if (r_byte)
                r_mem[r_idx][{r_lane, 3'b000} +: 8] <= r_wdata[7:0];
            else
                r_mem[r_idx] <= r_wdata;
        end
    end

    assign ReadData = r_rdata;
    assign MemReady = (r_state == S_RESP);
    assign MemErr   = (r_state == S_RESP) && r_err;

endmodule
